// File: rtl/tl_d_channel_queue_if.sv
// ---------------------------------------------------------------------------
// tl_d_channel_queue_if
//   One TileLink D-channel link: ready/valid handshake plus the seven beat
//   fields. The producer side of a link uses the master modport and the
//   consumer side uses the slave modport.
//
//   Signals
//     valid    producer -> consumer  beat present
//     ready    consumer -> producer  beat accepted this cycle
//     opcode   [2:0]                 TL D opcode
//     param    [1:0]                 TL D param
//     size     [3:0]                 TL D size (log2 bytes)
//     source   [2:0]                 TL D source ID
//     denied                         TL D denied
//     corrupt                        TL D corrupt
//     data     [DATA_W-1:0]          TL D data
// ---------------------------------------------------------------------------
interface tl_d_channel_queue_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [2:0]        opcode;
  logic [1:0]        param;
  logic [3:0]        size;
  logic [2:0]        source;
  logic              denied;
  logic              corrupt;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output opcode,
    output param,
    output size,
    output source,
    output denied,
    output corrupt,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  opcode,
    input  param,
    input  size,
    input  source,
    input  denied,
    input  corrupt,
    input  data,
    output ready
  );
endinterface

// File: rtl/tl_d_channel_queue.sv
// ---------------------------------------------------------------------------
// tl_d_channel_queue
//   Circular FIFO for TileLink D-channel beats. DEPTH entries (power of two,
//   2..8), no flow-through and no pipe path: a beat written this cycle is
//   visible at the head from the next cycle, and enq ready depends only on
//   occupancy. Beat contents are carried untouched.
//
//   Ports
//     i_clock   sole clock, rising edge
//     i_reset   synchronous, active-high; clears pointers and the full flag
//     enq       slave side of a D link (upstream pushes beats in)
//     deq       master side of a D link (head beat presented downstream)
//     o_count   current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module tl_d_channel_queue #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  tl_d_channel_queue_if.slave      enq,
  tl_d_channel_queue_if.master     deq,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Storage: one array per field. Deliberately not reset; the pointers and
  // the full flag alone decide which entries are meaningful.
  logic [2:0]        r_opcode  [DEPTH];
  logic [1:0]        r_param   [DEPTH];
  logic [3:0]        r_size    [DEPTH];
  logic [2:0]        r_source  [DEPTH];
  logic              r_denied  [DEPTH];
  logic              r_corrupt [DEPTH];
  logic [DATA_W-1:0] r_data    [DEPTH];

  logic [PTR_W-1:0]  r_enq_ptr;
  logic [PTR_W-1:0]  r_deq_ptr;
  logic              r_maybe_full;

  logic              w_ptr_match;
  logic              w_empty;
  logic              w_full;
  logic              w_do_enq;
  logic              w_do_deq;
  logic [PTR_W-1:0]  w_ptr_diff;

  assign w_ptr_match = (r_enq_ptr == r_deq_ptr);
  assign w_empty     = w_ptr_match && !r_maybe_full;
  assign w_full      = w_ptr_match &&  r_maybe_full;

  assign w_do_enq    = enq.valid && !w_full;
  assign w_do_deq    = !w_empty && deq.ready;

  // Handshake outputs depend on occupancy only.
  assign enq.ready   = !w_full;
  assign deq.valid   = !w_empty;

  // Head entry is read combinationally; it cannot change while it is not
  // popped because writes only ever target the enq pointer, which never
  // equals the deq pointer unless the queue is empty or full (and a full
  // queue refuses writes).
  assign deq.opcode  = r_opcode[r_deq_ptr];
  assign deq.param   = r_param[r_deq_ptr];
  assign deq.size    = r_size[r_deq_ptr];
  assign deq.source  = r_source[r_deq_ptr];
  assign deq.denied  = r_denied[r_deq_ptr];
  assign deq.corrupt = r_corrupt[r_deq_ptr];
  assign deq.data    = r_data[r_deq_ptr];

  // Power-of-two depth lets the pointer difference wrap naturally; the
  // ambiguous equal-pointer case is resolved by the full flag.
  assign w_ptr_diff  = r_enq_ptr - r_deq_ptr;
  assign o_count     = w_full ? CNT_W'(DEPTH) : {1'b0, w_ptr_diff};

  // A beat presented while reset is high must not land in storage.
  always_ff @(posedge i_clock) begin
    if (w_do_enq && !i_reset) begin
      r_opcode[r_enq_ptr]  <= enq.opcode;
      r_param[r_enq_ptr]   <= enq.param;
      r_size[r_enq_ptr]    <= enq.size;
      r_source[r_enq_ptr]  <= enq.source;
      r_denied[r_enq_ptr]  <= enq.denied;
      r_corrupt[r_enq_ptr] <= enq.corrupt;
      r_data[r_enq_ptr]    <= enq.data;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_enq_ptr    <= '0;
      r_deq_ptr    <= '0;
      r_maybe_full <= 1'b0;
    end else begin
      if (w_do_enq) begin
        r_enq_ptr <= r_enq_ptr + PTR_W'(1);
      end
      if (w_do_deq) begin
        r_deq_ptr <= r_deq_ptr + PTR_W'(1);
      end
      // Simultaneous push and pop leaves occupancy, and so the flag, alone.
      if (w_do_enq != w_do_deq) begin
        r_maybe_full <= w_do_enq;
      end
    end
  end

endmodule

// File: tb/tb_tl_d_channel_queue.sv
module tb_tl_d_channel_queue;

  localparam int DEPTH  = 2;
  localparam int DATA_W = 32;

  logic       clk;
  logic       rst;
  logic [1:0] count;

  int n_checks;
  int n_fail;

  tl_d_channel_queue_if #(.DATA_W(DATA_W)) enq_if ();
  tl_d_channel_queue_if #(.DATA_W(DATA_W)) deq_if ();

  tl_d_channel_queue #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .enq     (enq_if),
    .deq     (deq_if),
    .o_count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_enq(input logic v, input logic [2:0] op, input logic [1:0] prm,
                           input logic [3:0] sz, input logic [2:0] src,
                           input logic den, input logic cor, input logic [31:0] dat);
    enq_if.valid   = v;
    enq_if.opcode  = op;
    enq_if.param   = prm;
    enq_if.size    = sz;
    enq_if.source  = src;
    enq_if.denied  = den;
    enq_if.corrupt = cor;
    enq_if.data    = dat;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    deq_if.ready = 1'b0;
    drive_enq(1'b1, 3'd1, 2'd0, 4'd2, 3'd4, 1'b0, 1'b0, 32'h1111_2222);
    step();
    step();
    rst = 1'b0;
    drive_enq(1'b0, 3'd0, 2'd0, 4'd0, 3'd0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (deq_if.valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_deq_valid: got %b expected 0", deq_if.valid);
    end
    n_checks++;
    if (enq_if.ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_enq_ready: got %b expected 1", enq_if.ready);
    end
    n_checks++;
    if (count !== 2'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d expected 0", count);
    end
    step();
    n_checks++;
    if (count !== 2'd0 || deq_if.valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_enq_not_captured: count %0d valid %b expected 0 0", count, deq_if.valid);
    end
  endtask

  task automatic test_single_beat();
    drive_enq(1'b1, 3'd1, 2'd0, 4'd2, 3'd5, 1'b0, 1'b0, 32'hDEAD_BEEF);
    step();
    drive_enq(1'b0, 3'd0, 2'd0, 4'd0, 3'd0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (deq_if.valid !== 1'b1) begin
      n_fail++; $display("FAIL single_valid: got %b expected 1", deq_if.valid);
    end
    n_checks++;
    if (count !== 2'd1) begin
      n_fail++; $display("FAIL single_count: got %0d expected 1", count);
    end
    n_checks++;
    if (deq_if.opcode !== 3'd1 || deq_if.source !== 3'd5 || deq_if.size !== 4'd2) begin
      n_fail++; $display("FAIL single_fields: opcode %0d source %0d size %0d expected 1 5 2",
                         deq_if.opcode, deq_if.source, deq_if.size);
    end
    n_checks++;
    if (deq_if.data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL single_data: got %h expected deadbeef", deq_if.data);
    end
    deq_if.ready = 1'b1;
    step();
    deq_if.ready = 1'b0;
    n_checks++;
    if (count !== 2'd0 || deq_if.valid !== 1'b0) begin
      n_fail++; $display("FAIL single_pop: count %0d valid %b expected 0 0", count, deq_if.valid);
    end
    // Popping an empty queue must not move anything.
    deq_if.ready = 1'b1;
    step();
    deq_if.ready = 1'b0;
    n_checks++;
    if (count !== 2'd0 || enq_if.ready !== 1'b1) begin
      n_fail++; $display("FAIL empty_pop: count %0d enq_ready %b expected 0 1", count, enq_if.ready);
    end
  endtask

  task automatic test_fill();
    drive_enq(1'b1, 3'd1, 2'd0, 4'd2, 3'd1, 1'b0, 1'b0, 32'hA000_0001);
    step();
    drive_enq(1'b1, 3'd1, 2'd0, 4'd2, 3'd2, 1'b0, 1'b0, 32'hA000_0002);
    step();
    n_checks++;
    if (enq_if.ready !== 1'b0 || count !== 2'd2) begin
      n_fail++; $display("FAIL fill_full: enq_ready %b count %0d expected 0 2", enq_if.ready, count);
    end
    drive_enq(1'b1, 3'd1, 2'd0, 4'd2, 3'd3, 1'b0, 1'b0, 32'hA000_0003);
    step();
    drive_enq(1'b0, 3'd0, 2'd0, 4'd0, 3'd0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (count !== 2'd2 || deq_if.source !== 3'd1) begin
      n_fail++; $display("FAIL fill_drop: count %0d head source %0d expected 2 1", count, deq_if.source);
    end
    deq_if.ready = 1'b1;
    step();
    n_checks++;
    if (deq_if.source !== 3'd2 || deq_if.data !== 32'hA000_0002 || count !== 2'd1) begin
      n_fail++; $display("FAIL fill_drain_second: source %0d data %h count %0d expected 2 a0000002 1",
                         deq_if.source, deq_if.data, count);
    end
    step();
    deq_if.ready = 1'b0;
    n_checks++;
    if (count !== 2'd0 || deq_if.valid !== 1'b0) begin
      n_fail++; $display("FAIL fill_drain_empty: count %0d valid %b expected 0 0", count, deq_if.valid);
    end
  endtask

  task automatic test_simultaneous();
    drive_enq(1'b1, 3'd1, 2'd0, 4'd2, 3'd4, 1'b0, 1'b0, 32'hB000_0004);
    step();
    drive_enq(1'b1, 3'd1, 2'd0, 4'd2, 3'd5, 1'b0, 1'b0, 32'hB000_0005);
    step();
    drive_enq(1'b1, 3'd1, 2'd0, 4'd2, 3'd6, 1'b0, 1'b0, 32'hB000_0006);
    deq_if.ready = 1'b1;
    n_checks++;
    if (enq_if.ready !== 1'b0) begin
      n_fail++; $display("FAIL simul_enq_ready: got %b expected 0", enq_if.ready);
    end
    step();
    drive_enq(1'b0, 3'd0, 2'd0, 4'd0, 3'd0, 1'b0, 1'b0, 32'h0);
    deq_if.ready = 1'b0;
    n_checks++;
    if (count !== 2'd1 || deq_if.source !== 3'd5) begin
      n_fail++; $display("FAIL simul_pop: count %0d head source %0d expected 1 5", count, deq_if.source);
    end
    deq_if.ready = 1'b1;
    step();
    deq_if.ready = 1'b0;
    n_checks++;
    if (count !== 2'd0 || deq_if.valid !== 1'b0) begin
      n_fail++; $display("FAIL simul_no_enq: count %0d valid %b expected 0 0", count, deq_if.valid);
    end
  endtask

  task automatic test_stream();
    drive_enq(1'b1, 3'd1, 2'd0, 4'd2, 3'd0, 1'b0, 1'b0, 32'd100);
    step();
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (deq_if.data !== 32'(100 + i) || deq_if.valid !== 1'b1) begin
        n_fail++; $display("FAIL stream_head_%0d: data %0d valid %b expected %0d 1",
                           i, deq_if.data, deq_if.valid, 100 + i);
      end
      drive_enq(1'b1, 3'd1, 2'd0, 4'd2, 3'(i + 1), 1'b0, 1'b0, 32'(101 + i));
      deq_if.ready = 1'b1;
      step();
      n_checks++;
      if (count !== 2'd1) begin
        n_fail++; $display("FAIL stream_count_%0d: got %0d expected 1", i, count);
      end
    end
    drive_enq(1'b0, 3'd0, 2'd0, 4'd0, 3'd0, 1'b0, 1'b0, 32'h0);
    deq_if.ready = 1'b0;
    n_checks++;
    if (deq_if.data !== 32'd110 || deq_if.source !== 3'd2) begin
      n_fail++; $display("FAIL stream_last: data %0d source %0d expected 110 2", deq_if.data, deq_if.source);
    end
    deq_if.ready = 1'b1;
    step();
    deq_if.ready = 1'b0;
    n_checks++;
    if (count !== 2'd0) begin
      n_fail++; $display("FAIL stream_drain: count %0d expected 0", count);
    end
  endtask

  task automatic test_backpressure();
    deq_if.ready = 1'b0;
    drive_enq(1'b1, 3'd1, 2'd2, 4'd3, 3'd7, 1'b1, 1'b1, 32'hA5A5_5A5A);
    step();
    drive_enq(1'b1, 3'd0, 2'd1, 4'd6, 3'd3, 1'b0, 1'b0, 32'h1234_5678);
    step();
    for (int i = 0; i < 5; i++) begin
      drive_enq(1'b0, 3'(i), 2'(i), 4'(i), 3'(i), i[0], i[1], 32'(i * 7));
      n_checks++;
      if (deq_if.valid !== 1'b1 || deq_if.opcode !== 3'd1 || deq_if.param !== 2'd2 ||
          deq_if.size !== 4'd3 || deq_if.source !== 3'd7 || deq_if.data !== 32'hA5A5_5A5A) begin
        n_fail++; $display("FAIL bp_fields_%0d: v %b op %0d prm %0d sz %0d src %0d data %h expected 1 1 2 3 7 a5a55a5a",
                           i, deq_if.valid, deq_if.opcode, deq_if.param, deq_if.size, deq_if.source, deq_if.data);
      end
      n_checks++;
      if (deq_if.denied !== 1'b1 || deq_if.corrupt !== 1'b1) begin
        n_fail++; $display("FAIL bp_flags_%0d: denied %b corrupt %b expected 1 1", i, deq_if.denied, deq_if.corrupt);
      end
      step();
    end
    drive_enq(1'b0, 3'd0, 2'd0, 4'd0, 3'd0, 1'b0, 1'b0, 32'h0);
    deq_if.ready = 1'b1;
    step();
    n_checks++;
    if (deq_if.data !== 32'h1234_5678 || deq_if.denied !== 1'b0 || deq_if.corrupt !== 1'b0 || deq_if.param !== 2'd1) begin
      n_fail++; $display("FAIL bp_second: data %h den %b cor %b prm %0d expected 12345678 0 0 1",
                         deq_if.data, deq_if.denied, deq_if.corrupt, deq_if.param);
    end
    step();
    deq_if.ready = 1'b0;
  endtask

  task automatic test_reset_midflight();
    drive_enq(1'b1, 3'd1, 2'd0, 4'd2, 3'd1, 1'b0, 1'b0, 32'hC000_0001);
    step();
    drive_enq(1'b1, 3'd1, 2'd0, 4'd2, 3'd2, 1'b0, 1'b0, 32'hC000_0002);
    step();
    n_checks++;
    if (count !== 2'd2) begin
      n_fail++; $display("FAIL mid_pre_count: got %0d expected 2", count);
    end
    rst = 1'b1;
    drive_enq(1'b1, 3'd1, 2'd0, 4'd2, 3'd6, 1'b0, 1'b0, 32'hC000_0006);
    step();
    rst = 1'b0;
    drive_enq(1'b0, 3'd0, 2'd0, 4'd0, 3'd0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (deq_if.valid !== 1'b0 || count !== 2'd0 || enq_if.ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset: valid %b count %0d enq_ready %b expected 0 0 1",
                         deq_if.valid, count, enq_if.ready);
    end
    drive_enq(1'b1, 3'd4, 2'd0, 4'd1, 3'd3, 1'b0, 1'b1, 32'hC000_0003);
    step();
    drive_enq(1'b0, 3'd0, 2'd0, 4'd0, 3'd0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (count !== 2'd1 || deq_if.source !== 3'd3 || deq_if.corrupt !== 1'b1 || deq_if.data !== 32'hC000_0003) begin
      n_fail++; $display("FAIL mid_after: count %0d src %0d cor %b data %h expected 1 3 1 c0000003",
                         count, deq_if.source, deq_if.corrupt, deq_if.data);
    end
    deq_if.ready = 1'b1;
    step();
    deq_if.ready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    deq_if.ready = 1'b0;
    drive_enq(1'b0, 3'd0, 2'd0, 4'd0, 3'd0, 1'b0, 1'b0, 32'h0);
    test_reset();
    test_single_beat();
    test_fill();
    test_simultaneous();
    test_stream();
    test_backpressure();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tl_d_channel_queue.md
TL_D_CHANNEL_QUEUE -- requirements
Module: tl_d_channel_queue

Interface
REQ-001 Parameter DEPTH, default 2, entry count; power of two, 2..8.
REQ-002 Parameter DATA_W, default 32, D-channel data width.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enq_valid  input  1  upstream beat present.
REQ-006 enq_ready  output  1  queue accepts a beat this cycle.
REQ-007 enq_opcode  input  3  TL D opcode.
REQ-008 enq_param  input  2  TL D param.
REQ-009 enq_size  input  4  TL D size (log2 bytes).
REQ-010 enq_source  input  3  TL D source ID.
REQ-011 enq_denied  input  1  TL D denied.
REQ-012 enq_corrupt  input  1  TL D corrupt.
REQ-013 enq_data  input  DATA_W  TL D data.
REQ-014 deq_valid  output  1  head beat available to the downstream stage and its TileLink monitor.
REQ-015 deq_ready  input  1  downstream consumes head.
REQ-016 deq_opcode, deq_param, deq_size, deq_source, deq_denied, deq_corrupt, deq_data  outputs  same widths as the enq_* fields  head entry fields.
REQ-017 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-018 The block SHALL be a circular FIFO: storage array of DEPTH entries, enq_ptr and deq_ptr of $clog2(DEPTH) bits, and a separate maybe_full flag.
REQ-019 empty SHALL be (enq_ptr==deq_ptr && !maybe_full); full SHALL be (enq_ptr==deq_ptr && maybe_full).
REQ-020 enq_ready SHALL equal !full, independent of deq_ready (no pipe path).
REQ-021 deq_valid SHALL equal !empty; there is no flow-through, so minimum enq-to-deq latency is 1 cycle.
REQ-022 do_enq = enq_valid && enq_ready; on do_enq, all seven fields SHALL be written to entry[enq_ptr] and enq_ptr SHALL increment modulo DEPTH.
REQ-023 do_deq = deq_valid && deq_ready; on do_deq, deq_ptr SHALL increment modulo DEPTH.
REQ-024 maybe_full SHALL update only when do_enq != do_deq, taking the value of do_enq.
REQ-025 Simultaneous do_enq and do_deq SHALL leave count unchanged and SHALL NOT alter maybe_full.
REQ-026 deq_* fields SHALL be driven combinationally from entry[deq_ptr].
REQ-027 While deq_valid && !deq_ready, the deq_* fields SHALL remain stable.
REQ-028 Enqueue attempts while full SHALL be ignored: no write and no pointer change.
REQ-029 deq_ready while empty SHALL have no effect.
REQ-030 count SHALL equal DEPTH when full; otherwise it SHALL equal (enq_ptr - deq_ptr) mod DEPTH.
REQ-031 The block SHALL NOT inspect or alter beat contents; denied and corrupt SHALL pass through unmodified.
REQ-032 Storage entries SHALL NOT be reset; only pointers and maybe_full are reset.

Reset
REQ-033 While reset is high at a clock edge: enq_ptr=0, deq_ptr=0, maybe_full=0.
REQ-034 Consequently, from the first cycle after reset: deq_valid=0, enq_ready=1, count=0.
REQ-035 Reset asserted mid-operation SHALL discard all buffered beats.
REQ-036 enq_valid asserted in a cycle with reset high SHALL NOT be captured.
REQ-037 deq_* data fields are don't-care while deq_valid=0.

Verification
REQ-038 Single beat: enq opcode=1 (AccessAckData), source=5, data=0xDEADBEEF at cycle 0 -> deq_valid=1 at cycle 1 with identical fields, count=1; deq_ready=1 -> count=0 at cycle 2.
REQ-039 Fill: DEPTH=2, deq_ready=0, enqueue sources 1,2 -> enq_ready=0, count=2; a third beat (source 3) is dropped; draining yields sources 1, then 2.
REQ-040 Simultaneous: full queue, enq_valid=1 and deq_ready=1 -> head pops; enq_ready=0 that cycle, so no enqueue occurs; count goes 2->1.
REQ-041 Steady stream: count=1, enq and deq every cycle for 10 cycles -> count stays 1, beats emerge in order, pointers wrap cleanly.
REQ-042 Backpressure: head held 5 cycles with deq_ready=0 -> deq_* fields constant, denied and corrupt bits preserved.
REQ-043 Reset mid-flight: count=2, assert reset for 1 cycle -> next cycle deq_valid=0, count=0, enq_ready=1.
